// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter2
//  Purpose  : Two-master Wishbone arbiter. Ownership is held for the whole
//             cyc window of the granted master; ties go to the master that
//             was not granted last. A watchdog completes any strobe that no
//             slave acknowledges, returning OPEN_BUS read data.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
    parameter int          TIMEOUT  = 64,
    parameter logic [15:0] OPEN_BUS = 16'hFFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic [15:0] m0_dat_i,
    input  logic [18:0] m0_adr_i,
    input  logic        m0_we_i,
    input  logic        m0_tga_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,

    input  logic [15:0] m1_dat_i,
    input  logic [18:0] m1_adr_i,
    input  logic        m1_we_i,
    input  logic        m1_tga_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,

    output logic [15:0] s_dat_o,
    output logic [18:0] s_adr_o,
    output logic        s_we_o,
    output logic        s_tga_o,
    output logic [1:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o,
    output logic        to_o,
    input  logic        to_clr_i
);

    localparam int                C_WDOG_W   = $clog2(TIMEOUT + 1);
    localparam logic [C_WDOG_W-1:0] C_WDOG_MAX = C_WDOG_W'(TIMEOUT);
    localparam logic [C_WDOG_W-1:0] C_WDOG_ONE = C_WDOG_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q,  last_d;   // 1 = m1 was granted most recently
    logic [C_WDOG_W-1:0] wdog_q,  wdog_d;
    logic                to_q,    to_d;

    logic w_own0;
    logic w_own1;
    logic w_stb_raw;   // owner's strobe, qualified by its cyc (abort drops it)
    logic w_fire;      // watchdog completes the current strobe this cycle

    assign w_own0 = (state_q == ST_OWN0);
    assign w_own1 = (state_q == ST_OWN1);

    // Slave bus is a pure mux of the owner's signals; all zero when idle.
    always_comb begin
        s_cyc_o   = 1'b0;
        w_stb_raw = 1'b0;
        s_dat_o   = 16'h0000;
        s_adr_o   = 19'h00000;
        s_we_o    = 1'b0;
        s_tga_o   = 1'b0;
        s_sel_o   = 2'b00;
        if (w_own0) begin
            s_cyc_o   = m0_cyc_i;
            w_stb_raw = m0_cyc_i & m0_stb_i;
            s_dat_o   = m0_dat_i;
            s_adr_o   = m0_adr_i;
            s_we_o    = m0_we_i;
            s_tga_o   = m0_tga_i;
            s_sel_o   = m0_sel_i;
        end else if (w_own1) begin
            s_cyc_o   = m1_cyc_i;
            w_stb_raw = m1_cyc_i & m1_stb_i;
            s_dat_o   = m1_dat_i;
            s_adr_o   = m1_adr_i;
            s_we_o    = m1_we_i;
            s_tga_o   = m1_tga_i;
            s_sel_o   = m1_sel_i;
        end
    end

    // A slave ack in the expiry cycle wins over the watchdog.
    assign w_fire  = w_stb_raw & (wdog_q == C_WDOG_MAX) & ~s_ack_i;
    assign s_stb_o = w_stb_raw & ~w_fire;

    assign m0_ack_o = w_own0 & ((s_ack_i & s_stb_o) | w_fire);
    assign m1_ack_o = w_own1 & ((s_ack_i & s_stb_o) | w_fire);
    assign m0_dat_o = (w_own0 & w_fire) ? OPEN_BUS : s_dat_i;
    assign m1_dat_o = (w_own1 & w_fire) ? OPEN_BUS : s_dat_i;

    assign gnt_o = {w_own1, w_own0};
    assign to_o  = to_q;

    // Next-state: ownership, fairness bit, watchdog and timeout flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? ST_OWN0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        last_d = last_q;
        if ((state_d == ST_OWN0) && (state_q != ST_OWN0)) begin
            last_d = 1'b0;
        end else if ((state_d == ST_OWN1) && (state_q != ST_OWN1)) begin
            last_d = 1'b1;
        end

        // The watchdog never passes TIMEOUT: at TIMEOUT either an ack or
        // the forced completion (s_stb_o low) clears it.
        if (!s_stb_o || s_ack_i || (state_d != state_q)) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + C_WDOG_ONE;
        end

        if (to_clr_i) begin
            to_d = 1'b0;
        end else if (w_fire) begin
            to_d = 1'b1;
        end else begin
            to_d = to_q;
        end
    end

    // Arbiter state registers with asynchronous active-low reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            to_q    <= to_d;
        end
    end

endmodule
`default_nettype wire
